// File: rtl/i2c_slave.sv
// i2c_slave: oversampled I2C target with 7-bit address match and byte handshake
module i2c_slave #(
  parameter logic [6:0] SLAVE_ADDR = 7'h2A,
  parameter int SYNC_STAGES = 2
) (
  input  logic       clk,
  input  logic       rst,
  inout  wire        SDA,
  input  logic       SCL,
  input  logic [7:0] txData,
  output logic       txReq,
  output logic [7:0] rxData,
  output logic       rxValid,
  output logic       busy,
  output logic       addrHit
);
  typedef enum logic [2:0] {IDLE, ADDR, ADDR_ACK, WRITE, WRITE_ACK, READ, READ_ACK, IGNORE} state_t;
  state_t state, state_n;
  logic [SYNC_STAGES-1:0] scl_sync, sda_sync;
  logic scl_d, sda_d, scl_s, sda_s, rise, fall, start, stop;
  logic [7:0] sh, sh_n, sh_in, rx_n;
  logic [3:0] cnt, cnt_n;
  logic sda_low, sda_low_n, rw, rw_n, busy_n, tx_req_n, rx_valid_n, addr_hit_n;
  assign SDA = sda_low ? 1'b0 : 1'bz;
  assign scl_s = scl_sync[SYNC_STAGES-1];
  assign sda_s = sda_sync[SYNC_STAGES-1];
  assign rise = scl_s & ~scl_d;
  assign fall = ~scl_s & scl_d;
  assign start = scl_s & scl_d & sda_d & ~sda_s;
  assign stop = scl_s & scl_d & ~sda_d & sda_s;
  assign sh_in = {sh[6:0], sda_s};
  always_ff @(posedge clk) begin
    if (rst) begin
      scl_sync <= '1;
      sda_sync <= '1;
      scl_d <= 1'b1;
      sda_d <= 1'b1;
      state <= IDLE;
      sh <= '0;
      cnt <= '0;
      sda_low <= 1'b0;
      rw <= 1'b0;
      busy <= 1'b0;
      rxData <= '0;
      txReq <= 1'b0;
      rxValid <= 1'b0;
      addrHit <= 1'b0;
    end else begin
      scl_sync <= {scl_sync[SYNC_STAGES-2:0], SCL};
      sda_sync <= {sda_sync[SYNC_STAGES-2:0], SDA};
      scl_d <= scl_s;
      sda_d <= sda_s;
      state <= state_n;
      sh <= sh_n;
      cnt <= cnt_n;
      sda_low <= sda_low_n;
      rw <= rw_n;
      busy <= busy_n;
      rxData <= rx_n;
      txReq <= tx_req_n;
      rxValid <= rx_valid_n;
      addrHit <= addr_hit_n;
    end
  end
  always_comb begin
    state_n = state;
    sh_n = sh;
    cnt_n = cnt;
    sda_low_n = sda_low;
    rw_n = rw;
    busy_n = busy;
    rx_n = rxData;
    tx_req_n = 1'b0;
    rx_valid_n = 1'b0;
    addr_hit_n = 1'b0;
    if (stop) begin
      state_n = IDLE;
      sda_low_n = 1'b0;
      busy_n = 1'b0;
    end else if (start) begin
      state_n = ADDR;
      cnt_n = '0;
      sda_low_n = 1'b0;
    end else begin
      case (state)
        ADDR: if (rise) begin
          sh_n = sh_in;
          cnt_n = cnt + 4'd1;
          if (cnt == 4'd7) begin
            addr_hit_n = sh[6:0] == SLAVE_ADDR;
            busy_n = addr_hit_n;
            rw_n = sda_s;
            state_n = addr_hit_n ? ADDR_ACK : IGNORE;
          end
        end
        ADDR_ACK: if (fall) begin
          // first fall drives the ACK, second fall ends it and starts the data phase
          if (!sda_low) sda_low_n = 1'b1;
          else begin
            cnt_n = '0;
            tx_req_n = rw;
            sh_n = rw ? txData : sh;
            sda_low_n = rw & ~txData[7];
            state_n = rw ? READ : WRITE;
          end
        end
        WRITE: if (rise) begin
          sh_n = sh_in;
          cnt_n = cnt + 4'd1;
          rx_valid_n = cnt == 4'd7;
          rx_n = rx_valid_n ? sh_in : rxData;
        end else if (fall && cnt == 4'd8) begin
          sda_low_n = 1'b1;
          state_n = WRITE_ACK;
        end
        WRITE_ACK: if (fall) begin
          sda_low_n = 1'b0;
          cnt_n = '0;
          state_n = WRITE;
        end
        READ: if (rise) cnt_n = cnt + 4'd1;
        else if (fall) begin
          sda_low_n = cnt == 4'd8 ? 1'b0 : ~sh[6];
          sh_n = {sh[6:0], 1'b0};
          state_n = cnt == 4'd8 ? READ_ACK : READ;
        end
        READ_ACK: if (rise) begin
          // count 9 marks an ACKed byte awaiting the reload fall
          cnt_n = sda_s ? cnt : 4'd9;
          busy_n = ~sda_s;
          state_n = sda_s ? IGNORE : READ_ACK;
        end else if (fall && cnt == 4'd9) begin
          tx_req_n = 1'b1;
          sh_n = txData;
          sda_low_n = ~txData[7];
          cnt_n = '0;
          state_n = READ;
        end
        IGNORE: begin
          sda_low_n = 1'b0;
          busy_n = 1'b0;
        end
        default: ;
      endcase
    end
  end
endmodule

// File: tb/tb_i2c_slave.sv
// tb_i2c_slave: randomized bus-master bench with transaction-level reference model
module tb_i2c_slave;
  logic clk = 0, rst = 1, scl = 1, m_low = 0;
  logic tx_req, rx_valid, busy, addr_hit;
  logic [7:0] rx_data, tx_data;
  logic [7:0] dat [16];
  logic [7:0] rx_q [$];
  int n_cmp = 0, n_bad = 0, n_hit = 0, n_tx = 0;
  logic saw_low = 0;
  wire SDA;
  pullup (SDA);
  assign SDA = m_low ? 1'b0 : 1'bz;
  assign tx_data = dat[n_tx[3:0]];
  always #5 clk = ~clk;
  i2c_slave dut (.clk(clk), .rst(rst), .SDA(SDA), .SCL(scl), .txData(tx_data), .txReq(tx_req),
    .rxData(rx_data), .rxValid(rx_valid), .busy(busy), .addrHit(addr_hit));
  always @(negedge clk) begin
    if (addr_hit) n_hit++;
    if (rx_valid) rx_q.push_back(rx_data);
    if (tx_req) n_tx++;
    if (!m_low && SDA === 1'b0) saw_low = 1;
  end
  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
    end
  endtask
  task automatic tick(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask
  task automatic bit_cycle(input logic b, output logic r);
    scl = 0; tick(5); m_low = ~b; tick(5); scl = 1; tick(4); r = SDA; tick(4);
  endtask
  task automatic start_c();
    m_low = 0; scl = 1; tick(6); m_low = 1; tick(6);
  endtask
  task automatic rstart_c();
    scl = 0; tick(5); m_low = 0; tick(5); scl = 1; tick(6); m_low = 1; tick(6);
  endtask
  task automatic stop_c();
    scl = 0; tick(5); m_low = 1; tick(5); scl = 1; tick(6); m_low = 0; tick(6);
  endtask
  task automatic send_byte(input logic [7:0] b, output logic ack_n);
    logic r;
    for (int i = 7; i >= 0; i--) bit_cycle(b[i], r);
    bit_cycle(1'b1, ack_n);
  endtask
  task automatic recv_byte(output logic [7:0] d, input logic ack);
    logic r;
    for (int i = 0; i < 8; i++) begin
      bit_cycle(1'b1, r);
      d = {d[6:0], r};
    end
    bit_cycle(~ack, r);
  endtask
  task automatic clear();
    rx_q.delete(); n_hit = 0; n_tx = 0; saw_low = 0;
  endtask
  // one full transaction; expectations follow from whether the address is ours
  task automatic txn(input logic [6:0] a, input logic rw, input int n);
    logic ack_n, hit;
    logic [7:0] d;
    hit = a == 7'h2A;
    clear();
    start_c();
    send_byte({a, rw}, ack_n);
    chk("addr_ack", ack_n, !hit);
    chk("busy_txn", busy, hit);
    for (int i = 0; i < n; i++)
      if (!rw) begin
        send_byte(dat[i], ack_n);
        chk("wr_ack", ack_n, !hit);
      end else begin
        recv_byte(d, i != n - 1);
        chk("rd_data", d, hit ? dat[i] : 8'hFF);
      end
    stop_c();
    tick(4);
    chk("busy_idle", busy, 0);
    chk("hit_cnt", n_hit, hit);
    chk("rx_cnt", rx_q.size(), (hit && !rw) ? n : 0);
    for (int i = 0; i < rx_q.size() && i < n; i++) chk("rx_data", rx_q[i], dat[i]);
    chk("tx_cnt", n_tx, (hit && rw) ? n : 0);
    if (!hit) chk("no_drive", saw_low, 0);
  endtask
  initial begin
    logic ack_n;
    logic [7:0] d;
    for (int i = 0; i < 16; i++) dat[i] = 8'h00;
    tick(4);
    chk("rst_sda", SDA, 1);
    chk("rst_busy", busy, 0);
    chk("rst_rx", rx_data, 8'h00);
    chk("rst_pulses", {tx_req, rx_valid, addr_hit}, 3'b000);
    rst = 0;
    tick(4);
    dat[0] = 8'hA5;
    txn(7'h2A, 0, 1);
    dat[0] = 8'h3C; dat[1] = 8'hC3;
    txn(7'h2A, 1, 2);
    chk("nack_release", SDA, 1);
    dat[0] = 8'hFF;
    txn(7'h2B, 0, 1);
    dat[0] = 8'h01; dat[1] = 8'h80; dat[2] = 8'hFF;
    txn(7'h2A, 0, 3);
    clear();
    dat[0] = 8'h96;
    start_c();
    send_byte(8'h54, ack_n);
    chk("rs_ack1", ack_n, 0);
    for (int i = 0; i < 3; i++) bit_cycle(i[0], ack_n);
    rstart_c();
    send_byte(8'h55, ack_n);
    chk("rs_ack2", ack_n, 0);
    recv_byte(d, 0);
    chk("rs_data", d, 8'h96);
    stop_c();
    chk("rs_rxv", rx_q.size(), 0);
    chk("rs_hits", n_hit, 2);
    clear();
    dat[0] = 8'($urandom_range(0, 127));
    start_c();
    send_byte(8'h55, ack_n);
    chk("rr_ack", ack_n, 0);
    scl = 0; tick(5);
    chk("rr_drive", SDA, 0);
    rst = 1; tick(1);
    chk("rr_sda", SDA, 1);
    chk("rr_busy", busy, 0);
    chk("rr_rx", rx_data, 8'h00);
    chk("rr_pulses", {tx_req, rx_valid, addr_hit}, 3'b000);
    rst = 0; saw_low = 0;
    scl = 1; tick(8);
    for (int i = 0; i < 8; i++) bit_cycle(1'b1, ack_n);
    chk("rr_silent", saw_low, 0);
    chk("rr_tx", n_tx, 1);
    stop_c();
    for (int t = 0; t < 12; t++) begin
      int n;
      n = $urandom_range(1, 4);
      for (int i = 0; i < n; i++) dat[i] = 8'($urandom);
      txn($urandom_range(0, 2) == 0 ? 7'($urandom) : 7'h2A, 1'($urandom), n);
    end
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end
endmodule

// File: doc/i2c_slave.md
Name: i2c_slave

Overview:
- Clocked I2C target (slave). It is the responder counterpart to the team's I2C master.
- Oversamples SCL/SDA on the system clock and detects START/STOP.
- Matches a 7-bit address, then receives write bytes or supplies read bytes one at a time through a simple byte handshake.
- Drives SDA open-drain only; never drives SCL (no clock stretching).

Parameters:
- SLAVE_ADDR, 7'h2A, 7-bit bus address this target answers to.
- SYNC_STAGES, 2, synchronizer flops on SCL and SDA inputs (minimum 2).

Ports:
- clk  input  1  system clock; all logic on rising edge.
- rst  input  1  synchronous, active-high reset.
- SDA  inout  1  I2C data; driven 0 when sdaDriveLow=1, otherwise high-Z.
- SCL  input  1  I2C clock from master.
- txData  input  8  byte to send on the next read byte; sampled in the cycle txReq=1.
- txReq  output  1  one-cycle pulse: txData captured into the shift register.
- rxData  output  8  last received write byte; holds until the next byte.
- rxValid  output  1  one-cycle pulse: rxData updated.
- busy  output  1  high from an address match until STOP, or until START to another address.
- addrHit  output  1  one-cycle pulse on the 8th address bit when the address matches.

Behaviour:
- Reset values:
  - State IDLE; SDA released (sdaDriveLow=0); txReq=0, rxValid=0, addrHit=0, busy=0.
  - rxData=8'h00; shift register 0; bit counter 0.
- Input conditioning:
  - SCL/SDA pass through SYNC_STAGES flops; edges are detected against one further delayed copy.
  - Bus must hold SCL high and low phases >=4 clk cycles each; faster buses are unsupported.
- START: synchronized SDA falls while SCL high. Enter ADDR and clear the bit counter from any state, including mid-byte (repeated START).
- STOP: synchronized SDA rises while SCL high. Enter IDLE from any state, release SDA, busy=0.
- SDA sample/drive timing:
  - Data is sampled on the SCL rising edge, shifted in MSB first.
  - Slave-driven SDA changes only on the cycle after an SCL falling edge is detected.
- States:
  - IDLE: wait for START.
  - ADDR: shift 8 bits (7 address + R/W).
    - After the 8th rising edge, if the address equals SLAVE_ADDR: addrHit pulse, busy=1, go ADDR_ACK.
    - Otherwise go IGNORE.
  - ADDR_ACK: on the next SCL fall drive SDA low. On the following fall release SDA; then:
    - R/W=0: go WRITE.
    - R/W=1: pulse txReq, load txData, drive MSB, go READ.
  - WRITE: shift 8 bits. On the 8th rising edge update rxData and pulse rxValid. On the next fall drive ACK low, go WRITE_ACK.
  - WRITE_ACK: on the next fall release SDA and return to WRITE with counter 0.
  - READ: drive the current MSB on each SCL fall. After 8 bits, release SDA on the 8th fall and go READ_ACK.
  - READ_ACK: sample SDA on the 9th rising edge.
    - 0 (ACK): on the next fall pulse txReq, load txData, drive MSB, go READ.
    - 1 (NACK): go IGNORE.
  - IGNORE: SDA released, busy=0; wait for START or STOP.
- Simultaneous events:
  - START/STOP detection has priority over a bit event in the same cycle.
  - rst has priority over everything.
- Reset mid-transfer: SDA is released within 1 clk, the state returns to IDLE, and the current transaction is ignored until the next START.
- Bit counter is 4 bits and wraps to 0 at every ACK; no limit on the number of bytes per transaction.

Test Plan:
- Write: START, 0x54 (0x2A,W), 0xA5, STOP -> SDA low on both 9th clocks; addrHit one pulse; rxValid one pulse with rxData=8'hA5; busy back to 0 after STOP.
- Read: START, 0x55, txData=0x3C, master ACKs, then txData=0xC3, master NACKs, STOP -> bus carries 0x3C then 0xC3; exactly 2 txReq pulses; SDA released after the NACK.
- Address mismatch: START, 0x56 (0x2B,W), 0xFF -> SDA never driven low; no addrHit, rxValid or txReq; busy=0.
- Repeated START: START, 0x54, 3 bits of data, START, 0x55 -> second address ACKed and read begins; no rxValid for the partial byte.
- Multi-byte write: 0x54, then 0x01, 0x80, 0xFF -> 3 rxValid pulses with 01, 80, FF; 3 data ACKs.
- Reset mid-read: rst=1 for 1 clk while the slave drives SDA low -> SDA high-Z the next cycle, all outputs at reset values, no response until the next START.
